// File: rtl/dice_game_pkg.sv
// +--------------------------------------------------------------------+
// | dice_game_pkg : shared types and constants for the dice turn logic |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package dice_game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ROLL = 3'd1,
    REQ       = 3'd2,
    SCORE     = 3'd3,
    ADVANCE   = 3'd4,
    FINAL     = 3'd5
  } turn_state_t;

  localparam int DICE_MIN     = 1;
  localparam int DICE_MAX     = 6;
  localparam int PLAYER_IDX_W = 2;
  localparam int ROUND_W      = 4;

  function automatic logic dice_legal(input logic [2:0] v);
    return (v >= 3'(DICE_MIN)) && (v <= 3'(DICE_MAX));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dice_turn_sched_score_bank.sv
// +--------------------------------------------------------------------+
// | score_bank : per-player saturating scores plus winner/tie compare  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module score_bank
  import dice_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  input  logic                           add_en_i,
  input  logic [PLAYER_IDX_W-1:0]        add_idx_i,
  input  logic [2:0]                     add_val_i,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
  output logic [PLAYER_IDX_W-1:0]        winner_o,
  output logic                           tie_o
);

  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] max_v;
  logic [2:0]         n_max;

  generate
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      // One extra bit catches the carry so the add can clamp to all-ones.
      logic [SCORE_W:0] sum;
      assign sum = {1'b0, score_q[p]} + {{(SCORE_W-2){1'b0}}, add_val_i};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          score_q[p] <= '0;
        end else if (clr_i) begin
          score_q[p] <= '0;
        end else if (add_en_i && (add_idx_i == PLAYER_IDX_W'(p))) begin
          score_q[p] <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end
      end

      assign scores_o[p*SCORE_W +: SCORE_W] = score_q[p];
    end
  endgenerate

  // Strict greater-than keeps the lowest index on equal scores.
  always_comb begin
    max_v    = score_q[0];
    winner_o = '0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (score_q[p] > max_v) begin
        max_v    = score_q[p];
        winner_o = PLAYER_IDX_W'(p);
      end
    end
    n_max = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (score_q[p] == max_v) begin
        n_max = n_max + 3'd1;
      end
    end
    tie_o = (n_max > 3'd1);
  end

endmodule

`default_nettype wire

// File: rtl/dice_turn_sched.sv
// +--------------------------------------------------------------------+
// | dice_turn_sched : round-robin turn scheduler for a shared dice     |
// | roller. Optional bonus roll on a 6: define DICE_BONUS_ROLL_EN.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dice_turn_sched
  import dice_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_ROUNDS  = 5,
  parameter int SCORE_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           play_en,
  input  logic                           restart,
  input  logic                           roll_tick,
  input  logic                           dice_ack,
  input  logic [2:0]                     dice_val,
  output logic                           roll_req,
  output logic [1:0]                     cur_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [3:0]                     round_cnt,
  output logic                           game_final,
  output logic [1:0]                     winner,
  output logic                           tie
);

  turn_state_t              state_q, state_d;
  logic [PLAYER_IDX_W-1:0]  cur_q, cur_d;
  logic [ROUND_W-1:0]       round_q, round_d;
  logic [2:0]               dice_q, dice_d;
  logic                     req_q, req_d;
  logic                     final_q, final_d;
  logic [PLAYER_IDX_W-1:0]  winner_q, winner_d;
  logic                     tie_q, tie_d;
  logic                     add_en;
  logic                     clr;
  logic                     take_bonus;
  logic [PLAYER_IDX_W-1:0]  bank_winner;
  logic                     bank_tie;

`ifdef DICE_BONUS_ROLL_EN
  logic bonus_q, bonus_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bonus_q <= 1'b0;
    else     bonus_q <= bonus_d;
  end

  assign take_bonus = (dice_q == 3'(DICE_MAX)) && !bonus_q;

  // The flag survives the bonus turn and clears whenever the turn moves on.
  always_comb begin
    bonus_d = bonus_q;
    if (restart) begin
      bonus_d = 1'b0;
    end else if (state_q == ADVANCE && play_en) begin
      bonus_d = take_bonus;
    end
  end
`else
  assign take_bonus = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      round_q  <= '0;
      dice_q   <= '0;
      req_q    <= 1'b0;
      final_q  <= 1'b0;
      winner_q <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      round_q  <= round_d;
      dice_q   <= dice_d;
      req_q    <= req_d;
      final_q  <= final_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    round_d  = round_q;
    dice_d   = dice_q;
    final_d  = 1'b0;
    winner_d = winner_q;
    tie_d    = tie_q;
    add_en   = 1'b0;
    clr      = 1'b0;

    if (restart) begin
      // Restart outranks a same-cycle dice_ack, so its value is dropped.
      state_d  = WAIT_ROLL;
      cur_d    = '0;
      round_d  = '0;
      winner_d = '0;
      tie_d    = 1'b0;
      clr      = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (play_en) state_d = WAIT_ROLL;
        end
        WAIT_ROLL: begin
          if (play_en && roll_tick) state_d = REQ;
        end
        REQ: begin
          // Acks are accepted even while paused; SCORE holds the value.
          if (dice_ack) begin
            dice_d  = dice_val;
            state_d = SCORE;
          end
        end
        SCORE: begin
          if (play_en) begin
            if (dice_legal(dice_q)) begin
              add_en  = 1'b1;
              state_d = ADVANCE;
            end else begin
              state_d = REQ;
            end
          end
        end
        ADVANCE: begin
          if (play_en) begin
            state_d = WAIT_ROLL;
            if (!take_bonus) begin
              if (cur_q == PLAYER_IDX_W'(NUM_PLAYERS - 1)) begin
                cur_d   = '0;
                round_d = round_q + ROUND_W'(1);
                if (round_q == ROUND_W'(NUM_ROUNDS - 1)) begin
                  state_d  = FINAL;
                  final_d  = 1'b1;
                  winner_d = bank_winner;
                  tie_d    = bank_tie;
                end
              end else begin
                cur_d = cur_q + PLAYER_IDX_W'(1);
              end
            end
          end
        end
        FINAL: begin
          state_d = FINAL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    req_d = (state_d == REQ);
  end

  score_bank #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .SCORE_W     (SCORE_W)
  ) u_score_bank (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .add_en_i  (add_en),
    .add_idx_i (cur_q),
    .add_val_i (dice_q),
    .scores_o  (scores),
    .winner_o  (bank_winner),
    .tie_o     (bank_tie)
  );

  assign roll_req   = req_q;
  assign cur_player = cur_q;
  assign round_cnt  = round_q;
  assign game_final = final_q;
  assign winner     = winner_q;
  assign tie        = tie_q;

endmodule

`default_nettype wire

// File: tb/tb_dice_turn_sched.sv
// +--------------------------------------------------------------------+
// | tb_dice_turn_sched : randomized scoreboard bench for the scheduler |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dice_turn_sched;

  localparam int NP   = 3;
  localparam int NR   = 3;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, play_en, restart, roll_tick, dice_ack;
  logic [2:0]    dice_val;
  logic          roll_req, game_final, tie;
  logic [1:0]    cur_player, winner;
  logic [3:0]    round_cnt;
  logic [NP*SW-1:0] scores;

  always #5 clk = ~clk;

  dice_turn_sched #(.NUM_PLAYERS(NP), .NUM_ROUNDS(NR), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .play_en(play_en), .restart(restart),
    .roll_tick(roll_tick), .dice_ack(dice_ack), .dice_val(dice_val),
    .roll_req(roll_req), .cur_player(cur_player), .scores(scores),
    .round_cnt(round_cnt), .game_final(game_final), .winner(winner), .tie(tie)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [1:0] cur; logic [NP*SW-1:0] sc; } req_exp_t;
  typedef struct { logic [NP*SW-1:0] sc; logic [1:0] win; logic tie; logic [3:0] rnd; } fin_exp_t;
  req_exp_t req_q[$];
  fin_exp_t fin_q[$];

  // Reference model: game state as plain integers.
  int m_score[NP];
  int m_cur, m_round;
  bit m_bonus, m_final;
  int forced_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) m_score[p] = 0;
    m_cur = 0; m_round = 0; m_bonus = 0; m_final = 0;
  endfunction

  function automatic logic [NP*SW-1:0] m_pack();
    logic [NP*SW-1:0] pk;
    for (int p = 0; p < NP; p++) pk[p*SW +: SW] = SW'(m_score[p]);
    return pk;
  endfunction

  function automatic fin_exp_t m_result();
    fin_exp_t r;
    int mx = -1, w = 0, c = 0;
    for (int p = 0; p < NP; p++) if (m_score[p] > mx) begin mx = m_score[p]; w = p; end
    for (int p = 0; p < NP; p++) if (m_score[p] == mx) c++;
    r.sc = m_pack(); r.win = 2'(w); r.tie = (c > 1); r.rnd = 4'(m_round);
    return r;
  endfunction

  function automatic void model_roll(input int v);
    m_score[m_cur] = (m_score[m_cur] + v > SMAX) ? SMAX : m_score[m_cur] + v;
`ifdef DICE_BONUS_ROLL_EN
    if (v == 6 && !m_bonus) begin
      m_bonus = 1;
      return;
    end
`endif
    m_bonus = 0;
    m_cur++;
    if (m_cur == NP) begin
      m_cur = 0;
      m_round++;
      if (m_round == NR) m_final = 1;
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (roll_req) return;
    end
    total++; bad++;
    $display("FAIL roll_req_timeout: got 0 expected 1");
  endtask

  task automatic push_req();
    req_exp_t e;
    e.cur = 2'(m_cur); e.sc = m_pack();
    req_q.push_back(e);
  endtask

  // One turn: tick, then ack until a legal value is scored.
  task automatic do_roll(input bit pause);
    int v;
    push_req();
    roll_tick = 1'b1; step(); roll_tick = 1'b0;
    @(negedge clk);
    check("tick_to_req", {31'd0, roll_req}, 32'd1);
    for (int tries = 0; tries < 20; tries++) begin
      if (tries > 0) wait_req();
      step();
      repeat ($urandom_range(0, 2)) step();
      v = (forced_q.size() > 0) ? forced_q.pop_front() : int'($urandom_range(0, 7));
      if (pause) play_en = 1'b0;
      dice_ack = 1'b1; dice_val = 3'(v);
      step();
      dice_ack = 1'b0; dice_val = 3'($urandom);
      if (pause) begin
        @(negedge clk);
        check("pause_req_drop", {31'd0, roll_req}, 32'd0);
        check("pause_hold", 32'(scores), 32'(m_pack()));
        step(); step();
        play_en = 1'b1;
        @(negedge clk);
        check("pause_still_held", 32'(scores), 32'(m_pack()));
      end
      if (v >= 1 && v <= 6) begin
        model_roll(v);
        if (m_final) fin_q.push_back(m_result());
        if (pause) begin
          @(negedge clk);
          check("unpause_add", 32'(scores), 32'(m_pack()));
          step();
        end else begin
          repeat (3) step();
        end
        return;
      end
      push_req();
    end
  endtask

  // Monitor: compares against queued expectations whenever the DUT presents a request or final pulse.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (roll_req && !prev_req) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_roll_req: got 1 expected 0");
        end else begin
          req_exp_t e;
          e = req_q.pop_front();
          check("req_cur_player", 32'(cur_player), 32'(e.cur));
          check("req_scores", 32'(scores), 32'(e.sc));
        end
      end
      if (game_final) begin
        if (fin_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_game_final: got 1 expected 0");
        end else begin
          fin_exp_t f;
          f = fin_q.pop_front();
          check("final_scores", 32'(scores), 32'(f.sc));
          check("final_winner", 32'(winner), 32'(f.win));
          check("final_tie", {31'd0, tie}, {31'd0, f.tie});
          check("final_round_cnt", 32'(round_cnt), 32'(f.rnd));
          check("final_cur_player", 32'(cur_player), 32'd0);
        end
      end
    end
    prev_req = roll_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; play_en = 1'b0; restart = 1'b0; roll_tick = 1'b0;
    dice_ack = 1'b0; dice_val = 3'd0;
    model_reset();
    forced_q = '{0, 7, 2, 6, 6};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_roll_req", {31'd0, roll_req}, 32'd0);
    check("rst_cur_player", 32'(cur_player), 32'd0);
    check("rst_scores", 32'(scores), 32'd0);
    check("rst_round_cnt", 32'(round_cnt), 32'd0);
    check("rst_game_final", {31'd0, game_final}, 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_tie", {31'd0, tie}, 32'd0);
    step(); rst = 1'b0;
    play_en = 1'b1;
    repeat (2) step();

    for (int g = 0; g < 5; g++) begin
      for (int t = 0; t < 200 && !m_final; t++) begin
        do_roll($urandom_range(0, 3) == 0);
        if (g == 1 && t == 1) begin
          // Restart colliding with an ack mid-request: the ack must be discarded.
          push_req();
          roll_tick = 1'b1; step(); roll_tick = 1'b0;
          wait_req();
          step();
          restart = 1'b1; dice_ack = 1'b1; dice_val = 3'd5;
          step();
          restart = 1'b0; dice_ack = 1'b0;
          model_reset();
          @(negedge clk);
          check("restart_req_drop", {31'd0, roll_req}, 32'd0);
          check("restart_ack_discard", 32'(scores), 32'd0);
          step();
        end
      end
      roll_tick = 1'b1; step(); roll_tick = 1'b0;
      repeat (4) step();
      restart = 1'b1; step(); restart = 1'b0;
      model_reset();
      @(negedge clk);
      check("restart_scores", 32'(scores), 32'd0);
      check("restart_round_cnt", 32'(round_cnt), 32'd0);
      check("restart_winner", 32'(winner), 32'd0);
      check("restart_tie", {31'd0, tie}, 32'd0);
      check("restart_game_final", {31'd0, game_final}, 32'd0);
      check("restart_cur_player", 32'(cur_player), 32'd0);
      step();
    end

    repeat (5) step();
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("final_queue_drained", 32'(fin_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
